// File: rtl/ula_issue_pkg.sv
// ============================================================================
// Module      : ula_issue_pkg
// Description : Shared widths, buffer state encoding and entry record for the
//               ULA issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ula_issue_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;
    localparam int IMM_W  = 16;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [IMM_W-1:0]  imm;
        logic              use_imm;
        logic              fwd_a;
        logic              fwd_b;
    } entry_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_operand_mux.sv
// ============================================================================
// Module      : ula_operand_mux
// Description : Selects ULA operands A/B from the head entry. Forwarding is
//               honoured only when ULA_ISSUE_FWD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_operand_mux
    import ula_issue_pkg::*;
(
    input  entry_t            head,
    input  logic [DATA_W-1:0] last_result,
    output logic [DATA_W-1:0] a_sel,
    output logic [DATA_W-1:0] b_sel
);

`ifdef ULA_ISSUE_FWD_EN
    // Immediate wins over forwarding on B.
    always_comb begin
        a_sel = head.fwd_a ? last_result : head.a;
        if (head.use_imm) begin
            b_sel = sext_imm(head.imm);
        end else if (head.fwd_b) begin
            b_sel = last_result;
        end else begin
            b_sel = head.b;
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{head.fwd_a, head.fwd_b, last_result};

    always_comb begin
        a_sel = head.a;
        b_sel = head.use_imm ? sext_imm(head.imm) : head.b;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ula_issue.sv
// ============================================================================
// Module      : ula_issue
// Description : Two-entry (head/skid) in-order issue buffer feeding a ULA.
//               Optional result forwarding enabled by macro ULA_ISSUE_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_issue
    import ula_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic              in_fwd_a,
    input  logic              in_fwd_b,
    input  logic [DATA_W-1:0] ula_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [OP_W-1:0]   opcode,
    output logic [CNT_W-1:0]  issue_count
);

    logic [1:0]        state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            skid_q, skid_d;
    logic [DATA_W-1:0] a_hold_q, a_hold_d;
    logic [DATA_W-1:0] b_hold_q, b_hold_d;
    logic [OP_W-1:0]   op_hold_q, op_hold_d;
    logic [CNT_W-1:0]  issue_count_q, issue_count_d;

    logic              w_transfer;
    logic              w_issue;
    entry_t            w_new_entry;
    logic [DATA_W-1:0] w_a_sel;
    logic [DATA_W-1:0] w_b_sel;
    logic [DATA_W-1:0] w_last_result;

    assign in_ready    = (state_q != ST_FULL);
    assign out_valid   = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign w_transfer  = in_valid && in_ready;
    assign w_issue     = out_valid && out_ready;
    assign issue_count = issue_count_q;

    assign w_new_entry = '{opcode:  in_opcode,
                           a:       in_a,
                           b:       in_b,
                           imm:     in_imm,
                           use_imm: in_use_imm,
                           fwd_a:   in_fwd_a,
                           fwd_b:   in_fwd_b};

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_transfer) begin
                    head_d  = w_new_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_transfer && w_issue) begin
                    head_d = w_new_entry;
                end else if (w_transfer) begin
                    skid_d  = w_new_entry;
                    state_d = ST_FULL;
                end else if (w_issue) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_issue) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

`ifdef ULA_ISSUE_FWD_EN
    logic [DATA_W-1:0] last_result_q, last_result_d;

    always_comb begin
        last_result_d = w_issue ? ula_out : last_result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_result_q <= '0;
        end else begin
            last_result_q <= last_result_d;
        end
    end

    assign w_last_result = last_result_q;
`else
    logic w_unused_ula_out;
    assign w_unused_ula_out = ^ula_out;
    assign w_last_result    = '0;
`endif

    ula_operand_mux u_operand_mux (
        .head        (head_q),
        .last_result (w_last_result),
        .a_sel       (w_a_sel),
        .b_sel       (w_b_sel)
    );

    // Outputs track the head while valid and freeze on the last shown value otherwise.
    assign A      = out_valid ? w_a_sel       : a_hold_q;
    assign B      = out_valid ? w_b_sel       : b_hold_q;
    assign opcode = out_valid ? head_q.opcode : op_hold_q;

    always_comb begin
        a_hold_d      = A;
        b_hold_d      = B;
        op_hold_d     = opcode;
        issue_count_d = w_issue ? issue_count_q + CNT_W'(1) : issue_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            head_q        <= '0;
            skid_q        <= '0;
            a_hold_q      <= '0;
            b_hold_q      <= '0;
            op_hold_q     <= '0;
            issue_count_q <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            skid_q        <= skid_d;
            a_hold_q      <= a_hold_d;
            b_hold_q      <= b_hold_d;
            op_hold_q     <= op_hold_d;
            issue_count_q <= issue_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ula_issue.sv
// ============================================================================
// Module      : tb_ula_issue
// Description : Self-checking bench for ula_issue (directed table, corner
//               sequences, random traffic against a queue-based model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_issue;

`ifdef ULA_ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic        in_fwd_a;
    logic        in_fwd_b;
    logic [31:0] ula_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  opcode;
    logic [15:0] issue_count;

    ula_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_fwd_a    (in_fwd_a),
        .in_fwd_b    (in_fwd_b),
        .ula_out     (ula_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .A           (A),
        .B           (B),
        .opcode      (opcode),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [15:0] imm,
                            input logic ui, input logic fa, input logic fb);
        in_valid   = v;
        in_opcode  = op;
        in_a       = a;
        in_b       = b;
        in_imm     = imm;
        in_use_imm = ui;
        in_fwd_a   = fa;
        in_fwd_b   = fb;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ula_out   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic        ui;
        logic        fa;
        logic        fb;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_lr;
    logic [31:0] m_ha;
    logic [31:0] m_hb;
    logic [4:0]  m_hop;
    int          m_cnt;

    function automatic logic [31:0] sx(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [31:0] ref_a(input ent_t e, input logic [31:0] lr);
        return (FWD && e.fa) ? lr : e.a;
    endfunction

    function automatic logic [31:0] ref_b(input ent_t e, input logic [31:0] lr);
        if (e.ui) return sx(e.imm);
        if (FWD && e.fb) return lr;
        return e.b;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_lr  = '0;
        m_ha  = '0;
        m_hb  = '0;
        m_hop = '0;
        m_cnt = 0;
    endtask

    task automatic model_check();
        logic [31:0] ea, eb;
        logic [4:0]  eo;
        if (mq.size() > 0) begin
            ea = ref_a(mq[0], m_lr);
            eb = ref_b(mq[0], m_lr);
            eo = mq[0].op;
        end else begin
            ea = m_ha;
            eb = m_hb;
            eo = m_hop;
        end
        chk("rnd_in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("rnd_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("rnd_A", A, ea);
        chk("rnd_B", B, eb);
        chk("rnd_opcode", 32'(opcode), 32'(eo));
        chk("rnd_issue_count", 32'(issue_count), 32'(m_cnt % 65536));
    endtask

    task automatic model_advance();
        bit   xfer, iss;
        ent_t e;
        xfer = in_valid && (mq.size() < 2);
        iss  = out_ready && (mq.size() > 0);
        if (mq.size() > 0) begin
            m_ha  = ref_a(mq[0], m_lr);
            m_hb  = ref_b(mq[0], m_lr);
            m_hop = mq[0].op;
        end
        if (iss) begin
            m_lr = ula_out;
            m_cnt++;
            void'(mq.pop_front());
        end
        if (xfer) begin
            e.op = in_opcode; e.a = in_a; e.b = in_b; e.imm = in_imm;
            e.ui = in_use_imm; e.fa = in_fwd_a; e.fb = in_fwd_b;
            mq.push_back(e);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic        ui;
        logic        fa;
        logic        fb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    localparam logic [31:0] TBL_LR = 32'h1234_5678;
    vec_t tbl[6];

    initial begin
        int exp_cnt;
        tbl[0] = '{5'h02, 32'hDEAD_BEEF, 32'h0000_0001, 16'h0000, 1'b0, 1'b0, 1'b0,
                   32'hDEAD_BEEF, 32'h0000_0001};
        tbl[1] = '{5'h07, 32'h0000_0000, 32'hFFFF_FFFF, 16'h7FFF, 1'b1, 1'b0, 1'b0,
                   32'h0000_0000, 32'h0000_7FFF};
        tbl[2] = '{5'h1F, 32'h8000_0000, 32'h0000_0005, 16'hFFFE, 1'b1, 1'b0, 1'b1,
                   32'h8000_0000, 32'hFFFF_FFFE};
        tbl[3] = '{5'h09, 32'h0000_00AA, 32'h0000_00BB, 16'h0000, 1'b0, 1'b1, 1'b0,
                   FWD ? TBL_LR : 32'h0000_00AA, 32'h0000_00BB};
        tbl[4] = '{5'h10, 32'h0000_0001, 32'h0000_0002, 16'h0000, 1'b0, 1'b0, 1'b1,
                   32'h0000_0001, FWD ? TBL_LR : 32'h0000_0002};
        tbl[5] = '{5'h00, 32'h0000_0007, 32'h0000_0008, 16'h8000, 1'b1, 1'b1, 1'b1,
                   FWD ? TBL_LR : 32'h0000_0007, 32'hFFFF_8000};

        rst_n = 1'b0;
        drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        ula_out   = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_A", A, 32'd0);
        chk("rst_B", B, 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_issue_count", 32'(issue_count), 32'd0);
        do_reset();

        // pass-through
        drive_op(1'b1, 5'b00001, 32'd5, 32'd3, 16'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        ula_out   = 32'd8;
        step();
        drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("pt_out_valid", 32'(out_valid), 32'd1);
        chk("pt_A", A, 32'd5);
        chk("pt_B", B, 32'd3);
        chk("pt_opcode", 32'(opcode), 32'd1);
        chk("pt_count_before", 32'(issue_count), 32'd0);
        step();
        chk("pt_count_after", 32'(issue_count), 32'd1);
        chk("pt_idle_valid", 32'(out_valid), 32'd0);
        chk("pt_hold_A", A, 32'd5);

        // forwarding of the result latched at the previous issue
        drive_op(1'b1, 5'b00101, 32'd1, 32'd0, 16'h0, 1'b0, 1'b1, 1'b0);
        ula_out = 32'd99;
        step();
        drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("fwd_A", A, FWD ? 32'd8 : 32'd1);
        step();
        chk("fwd_count", 32'(issue_count), 32'd2);

        // directed table
        exp_cnt = 2;
        ula_out = TBL_LR;
        for (int i = 0; i < 6; i++) begin
            drive_op(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm,
                     tbl[i].ui, tbl[i].fa, tbl[i].fb);
            step();
            drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_A", i), A, tbl[i].ea);
            chk($sformatf("tbl%0d_B", i), B, tbl[i].eb);
            chk($sformatf("tbl%0d_opcode", i), 32'(opcode), 32'(tbl[i].op));
            step();
            exp_cnt++;
            chk($sformatf("tbl%0d_count", i), 32'(issue_count), 32'(exp_cnt));
        end

        // backpressure: X then Y held, then drained in order
        out_ready = 1'b0;
        drive_op(1'b1, 5'b00011, 32'd11, 32'd12, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_ready_one", 32'(in_ready), 32'd1);
        drive_op(1'b1, 5'b00100, 32'd21, 32'd22, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_X", 32'(opcode), 32'd3);
        chk("bp_A_X", A, 32'd11);
        out_ready = 1'b1;
        step();
        chk("bp_head_Y", 32'(opcode), 32'd4);
        chk("bp_A_Y", A, 32'd21);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(issue_count), 32'(exp_cnt + 2));

        // reset asserted mid-cycle while FULL
        out_ready = 1'b0;
        drive_op(1'b1, 5'd6, 32'd1, 32'd2, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive_op(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("mr_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_count", 32'(issue_count), 32'd0);
        chk("mr_A", A, 32'd0);
        chk("mr_opcode", 32'(opcode), 32'd0);
        do_reset();
        out_ready = 1'b1;
        step();
        chk("mr_discarded", 32'(out_valid), 32'd0);

        // random traffic against the model
        do_reset();
        model_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            in_opcode  = 5'($urandom);
            in_a       = $urandom;
            in_b       = $urandom;
            in_imm     = 16'($urandom);
            in_use_imm = 1'($urandom);
            in_fwd_a   = 1'($urandom);
            in_fwd_b   = 1'($urandom);
            ula_out    = $urandom;
            @(negedge clk);
            model_check();
            model_advance();
            step();
        end

        // counter wrap
        do_reset();
        drive_op(1'b1, 5'd1, 32'd0, 32'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        repeat (65535) step();
        chk("wrap_ffff", 32'(issue_count), 32'h0000_FFFF);
        step();
        chk("wrap_zero", 32'(issue_count), 32'd0);
        in_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
